// File: rtl/seq_mask_multiplier.sv
// Sequential shift-and-add multiplier: one masked partial product per cycle,
// start/busy/done handshake, optional two's-complement operands.
module seq_mask_multiplier #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 tc,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   // Magnitude of a two's-complement word; the most negative value maps onto
   // itself, which is exactly its magnitude when read as unsigned.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      if (x[WIDTH-1]) begin
         r = ~x + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         r = x;
      end
      return r;
   endfunction

   state_t               state_r,  state_s;
   logic [WIDTH-1:0]     mcand_r,  mcand_s;
   logic [WIDTH-1:0]     mplier_r, mplier_s;
   logic [2*WIDTH-1:0]   acc_r,    acc_s;
   logic [CNT_W-1:0]     cnt_r,    cnt_s;
   logic                 neg_r,    neg_s;
   logic [2*WIDTH-1:0]   product_r, product_s;
   logic                 busy_r,   busy_s;
   logic                 done_r,   done_s;

   logic [WIDTH-1:0]     pp_s;
   logic [2*WIDTH-1:0]   sum_s;

   assign pp_s  = mcand_r & {WIDTH{mplier_r[0]}};
   assign sum_s = acc_r + ({{WIDTH{1'b0}}, pp_s} << cnt_r);

   // Next-state, datapath and output decode.
   always_comb begin
      state_s   = state_r;
      mcand_s   = mcand_r;
      mplier_s  = mplier_r;
      acc_s     = acc_r;
      cnt_s     = cnt_r;
      neg_s     = neg_r;
      product_s = product_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_s  = ST_RUN;
               busy_s   = 1'b1;
               mcand_s  = tc ? abs_val(a) : a;
               mplier_s = tc ? abs_val(b) : b;
               neg_s    = tc & (a[WIDTH-1] ^ b[WIDTH-1]);
               acc_s    = {(2*WIDTH){1'b0}};
               cnt_s    = {CNT_W{1'b0}};
            end else begin
               state_s  = ST_IDLE;
               busy_s   = 1'b0;
            end
         end
         ST_RUN: begin
            acc_s    = sum_s;
            mplier_s = mplier_r >> 1;
            cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_r == LAST_STEP) begin
               state_s   = ST_DONE;
               busy_s    = 1'b0;
               done_s    = 1'b1;
               product_s = neg_r ? (~sum_s + {{(2*WIDTH-1){1'b0}}, 1'b1}) : sum_s;
            end else begin
               state_s   = ST_RUN;
            end
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         mcand_r   <= {WIDTH{1'b0}};
         mplier_r  <= {WIDTH{1'b0}};
         acc_r     <= {(2*WIDTH){1'b0}};
         cnt_r     <= {CNT_W{1'b0}};
         neg_r     <= 1'b0;
         product_r <= {(2*WIDTH){1'b0}};
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         mcand_r   <= mcand_s;
         mplier_r  <= mplier_s;
         acc_r     <= acc_s;
         cnt_r     <= cnt_s;
         neg_r     <= neg_s;
         product_r <= product_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
      end
   end

   assign busy    = busy_r;
   assign done    = done_r;
   assign product = product_r;

endmodule

// File: tb/tb_seq_mask_multiplier.sv
// Scoreboard bench for seq_mask_multiplier at WIDTH=8 and WIDTH=16: the driver
// pushes reference results, a negedge monitor pops and checks them.
module tb_seq_mask_multiplier;

   typedef struct {
      logic [31:0] exp;
      int          due;
   } item_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start8 = 1'b0, tc8 = 1'b0;
   logic [7:0]  a8 = 8'h00, b8 = 8'h00;
   logic        busy8, done8;
   logic [15:0] prod8;
   logic        start16 = 1'b0, tc16 = 1'b0;
   logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
   logic        busy16, done16;
   logic [31:0] prod16;

   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   item_t       sb0[$];
   item_t       sb1[$];
   logic [31:0] held[2];

   seq_mask_multiplier #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .tc(tc8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(prod8)
   );

   seq_mask_multiplier #(.WIDTH(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .start(start16), .tc(tc16), .a(a16), .b(b16),
      .busy(busy16), .done(done16), .product(prod16)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Signed/unsigned product from plain integer arithmetic, truncated to 2*w bits.
   function automatic logic [31:0] model(input logic t, input logic [15:0] x,
                                         input logic [15:0] y, input int w);
      longint m  = longint'(1) << w;
      longint sa = longint'(x) & (m - 1);
      longint sb = longint'(y) & (m - 1);
      longint p;
      if (t && sa >= m / 2) sa = sa - m;
      if (t && sb >= m / 2) sb = sb - m;
      p = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
      return p[31:0];
   endfunction

   task automatic chk(input int d, input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (w%0d) at cycle %0d: got %h, expected %h",
                  nm, (d == 0) ? 8 : 16, cyc, act, exp);
      end
   endtask

   task automatic mon(input int d, input logic dn, input logic bz,
                      input logic [31:0] pr, input int w);
      item_t f;
      int    n;
      logic  exp_busy;
      n = (d == 0) ? sb0.size() : sb1.size();
      if (n > 0) f = (d == 0) ? sb0[0] : sb1[0];
      if (dn) begin
         if (n == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done (w%0d) at cycle %0d: got done=1, expected 0", w, cyc);
         end else begin
            chk(d, "product", pr, f.exp);
            chk(d, "done_cycle", 32'(cyc), 32'(f.due));
            held[d] = f.exp;
            if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            n--;
         end
      end else begin
         if (n > 0 && cyc >= f.due) begin
            checks++; errors++;
            $display("FAIL missing_done (w%0d) at cycle %0d: got done=0, expected 1 at cycle %0d", w, cyc, f.due);
            if (d == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
            n--;
         end
         chk(d, "product_hold", pr, held[d]);
      end
      if (n > 0) f = (d == 0) ? sb0[0] : sb1[0];
      exp_busy = (n > 0) && (cyc >= f.due - w) && (cyc < f.due);
      chk(d, "busy", {31'd0, bz}, {31'd0, exp_busy});
   endtask

   // Monitor: compare both DUTs against the scoreboard on every falling edge.
   always @(negedge clk) begin
      mon(0, done8, busy8, {16'd0, prod8}, 8);
      mon(1, done16, busy16, prod16, 16);
   end

   // Present one operation right after a rising edge; it is accepted on the next one.
   task automatic issue(input int d, input logic t, input logic [15:0] x,
                        input logic [15:0] y);
      item_t it;
      int    w = (d == 0) ? 8 : 16;
      it.exp = model(t, x, y, w);
      it.due = cyc + 1 + w;
      if (d == 0) begin
         start8 = 1'b1; tc8 = t; a8 = x[7:0]; b8 = y[7:0]; sb0.push_back(it);
      end else begin
         start16 = 1'b1; tc16 = t; a16 = x; b16 = y; sb1.push_back(it);
      end
      @(posedge clk); #1;
      start8 = 1'b0; start16 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); a16 = 16'($urandom); b16 = 16'($urandom);
   endtask

   // Issue, then advance to the cycle in which done is due.
   task automatic op(input int d, input logic t, input logic [15:0] x,
                     input logic [15:0] y);
      issue(d, t, x, y);
      repeat ((d == 0) ? 8 : 16) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      held[0] = 32'd0;
      held[1] = 32'd0;
      #3;
      chk(0, "reset_busy", {31'd0, busy8}, 32'd0);
      chk(0, "reset_done", {31'd0, done8}, 32'd0);
      chk(0, "reset_product", {16'd0, prod8}, 32'd0);
      chk(1, "reset_product", prod16, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(1);

      op(0, 1'b0, 16'h00FF, 16'h00FF); idle(1);
      op(0, 1'b1, 16'h0080, 16'h0080); idle(1);
      op(0, 1'b1, 16'h0080, 16'h0001); idle(1);
      op(0, 1'b1, 16'h00FD, 16'h0005); idle(1);
      op(0, 1'b1, 16'h0000, 16'h009C); idle(1);

      // Back-to-back: next start presented during the DONE cycle.
      op(0, 1'b0, 16'h00A5, 16'h003C);
      op(0, 1'b0, 16'h0012, 16'h0034); idle(1);

      // Start re-pulsed with new operands while busy must be ignored.
      issue(0, 1'b1, 16'h00B7, 16'h0063);
      idle(2);
      start8 = 1'b1; tc8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      idle(1);
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      idle(5);
      idle(2);

      // Reset in the middle of a run.
      issue(0, 1'b1, 16'h0071, 16'h00E9);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      sb0.delete(); sb1.delete();
      held[0] = 32'd0; held[1] = 32'd0;
      #1;
      chk(0, "abort_busy", {31'd0, busy8}, 32'd0);
      chk(0, "abort_done", {31'd0, done8}, 32'd0);
      chk(0, "abort_product", {16'd0, prod8}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(12);
      op(0, 1'b0, 16'h0013, 16'h0011); idle(1);

      op(1, 1'b1, 16'hFFFF, 16'h0002); idle(1);
      op(1, 1'b1, 16'h8000, 16'h8000); idle(1);

      for (int i = 0; i < 40; i++) begin
         int d = int'($urandom_range(0, 1));
         op(d, 1'($urandom), 16'($urandom), 16'($urandom));
         if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 2)));
      end

      idle(20);
      chk(0, "scoreboard_drained", 32'(sb0.size()), 32'd0);
      chk(1, "scoreboard_drained", 32'(sb1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_mask_multiplier.md
Name: seq_mask_multiplier

Overview:
Parametrised sequential shift-and-add multiplier built on masked partial products. Each cycle it ANDs the multiplicand with one multiplier bit and accumulates the result. It replaces the fixed 8-bit combinational mask/add array in the Arithmetic/Multiplier datapath. It adds a start/done handshake, a busy flag and an optional two's-complement mode.

Parameters:
WIDTH, 8, operand width in bits (minimum 2); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH)+1, width of the internal step counter (derived, do not override)

Ports:
clk      input   1          rising-edge clock
rst_n    input   1          asynchronous active-low reset
start    input   1          request; sampled only when busy=0
tc       input   1          1 = operands/product two's complement, 0 = unsigned; sampled with start
a        input   WIDTH      multiplicand; sampled with start
b        input   WIDTH      multiplier; sampled with start
busy     output  1          high while a multiplication is in progress
done     output  1          single-cycle pulse: product valid
product  output  2*WIDTH    result; held stable until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, done=0, product=0, accumulator/counter/sign flag=0. Reset mid-operation aborts; no done pulse follows.
- States:
  - IDLE: wait for start.
  - RUN: WIDTH steps.
  - DONE: one cycle, done=1.
- IDLE or DONE with start=1 → RUN. Start is accepted in DONE, giving back-to-back operation.
- Accept (edge k):
  - tc=1: latch mcand=|a|, mplier=|b|, neg=a[MSB]^b[MSB].
  - tc=0: latch raw values, neg=0.
  - Clear the accumulator and counter.
  - |−2^(WIDTH−1)| = 2^(WIDTH−1) fits in WIDTH unsigned bits. No overflow case exists.
- RUN step i (i=0..WIDTH−1):
  - pp = mcand AND {WIDTH{mplier[0]}}, the masked partial product.
  - acc = acc + (pp zero-extended to 2*WIDTH, shifted left by i).
  - Shift mplier right by 1.
  - Increment counter.
  - Exactly WIDTH RUN cycles; no early termination, so latency is data-independent.
- After the last step → DONE.
  - product = neg ? (two's complement of acc) : acc, registered on that edge.
  - A zero result with neg=1 yields 0.
- Timing: start sampled at edge k.
  - busy=1 for cycles k+1..k+WIDTH.
  - done=1 and product updated at cycle k+WIDTH+1.
  - busy=0 in the DONE cycle.
  - Latency start→done = WIDTH+1 cycles.
- start while busy=1 is ignored. Operand changes during RUN have no effect.
- DONE with start=0 → IDLE. The product keeps its last value and done drops after one cycle.
- tc=0 ignores sign bits entirely: 0xFF×0xFF = 0xFE01 at WIDTH=8.
- All arithmetic is modulo 2^(2*WIDTH) and is exact for both modes.

Test Plan:
- WIDTH=8, tc=0, a=0xFF, b=0xFF, start pulse → busy high 8 cycles; done pulse on cycle 9; product=0xFE01.
- WIDTH=8, tc=1, a=0x80 (−128), b=0x80 (−128) → product=0x4000. Then a=0x80, b=0x01 → product=0xFF80.
- WIDTH=8, tc=1, a=0xFD (−3), b=0x05 → product=0xFFF1. Then a=0x00, b=0x9C → product=0x0000, no −0 artifact.
- Back-to-back: assert start in the DONE cycle with a=0x12, b=0x34, tc=0 → previous product seen with done; new product=0x03A8 exactly 9 cycles later.
- start re-pulsed and a/b changed during RUN → ignored; the original result is delivered on schedule; exactly one done pulse.
- rst_n driven low at RUN step 4 → busy, done and product become 0 immediately; no done after release; the next start completes normally. Repeat with WIDTH=16: a=0xFFFF, b=0x0002, tc=1 → product=0xFFFFFFFE after 17 cycles.
